// File: rtl/arty_pkg.sv
// Shared definitions for the Arty reset sequencer.
//   state_width_gp      width of the sequencer state / debug encoding
//   sync_min_stages_gp  smallest legal synchronizer depth
//   arty_rst_state_e    sequencer state encoding (also driven onto the LEDs)
package arty_pkg;

  localparam int unsigned state_width_gp     = 3;
  localparam int unsigned sync_min_stages_gp = 2;

  typedef enum logic [state_width_gp-1:0] {
    e_reset      = 3'd0,
    e_wait_lock  = 3'd1,
    e_wait_calib = 3'd2,
    e_host_lead  = 3'd3,
    e_core_hold  = 3'd4,
    e_run        = 3'd5,
    e_soft_rst   = 3'd6,
    e_error      = 3'd7
  } arty_rst_state_e;

  // Larger of two counts; used to size the shared down-counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // States in which the FPGA host is allowed out of reset.
  function automatic logic host_released(input arty_rst_state_e s);
    return (s == e_host_lead) || (s == e_core_hold) ||
           (s == e_run)       || (s == e_soft_rst);
  endfunction

endpackage

// File: rtl/arty_sync_bit.sv
// N-stage single-bit synchronizer with asynchronous active-low clear.
// With d_i tied high it doubles as a reset deassertion synchronizer:
// q_o drops immediately on clr_n_i and rises stages_p clocks after release.
//   clk_i    destination clock
//   clr_n_i  asynchronous clear, active low
//   d_i      asynchronous input bit
//   q_o      synchronized output (registered)
module arty_sync_bit
  import arty_pkg::*;
#(
  parameter int unsigned stages_p = 2
) (
  input  logic clk_i,
  input  logic clr_n_i,
  input  logic d_i,
  output logic q_o
);

  if (stages_p < sync_min_stages_gp) begin : g_bad_stages
    $fatal(1, "arty_sync_bit: stages_p must be at least 2");
  end

  logic [stages_p-1:0] sync_q;

  // Shift chain; only the first flop may go metastable.
  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[stages_p-2:0], d_i};
    end
  end

  assign q_o = sync_q[stages_p-1];

endmodule

// File: rtl/arty_reset_sequencer.sv
// Reset bring-up sequencer between the clock generator / MIG DDR3 controller
// and the core-clock consumers (bp_unicore and the FPGA host).
// Holds both in reset until MMCM lock and DDR3 calibration, releases the host
// first and the core a programmable lead later, and handles lock/calibration
// loss, host-requested core soft resets and calibration timeout.
//   clk_i                  core clock
//   reset_n_i              board reset, async assert, synchronized release
//   mmcm_locked_i          MMCM lock (asynchronous)
//   init_calib_complete_i  MIG calibration done (MIG UI clock domain)
//   soft_reset_req_i       one-cycle core-only reset request from the host
//   host_reset_o           active-high reset to the FPGA host
//   core_reset_o           active-high reset to bp_unicore
//   dram_ready_o           synchronized calibration done, qualified by lock
//   timeout_error_o        sticky calibration timeout flag
//   state_o                current sequencer state for LEDs/debug
module arty_reset_sequencer
  import arty_pkg::*;
#(
  parameter int unsigned sync_stages_p          = 2,
  parameter int unsigned host_lead_cycles_p     = 8,
  parameter int unsigned core_hold_cycles_p     = 16,
  parameter int unsigned soft_reset_cycles_p    = 16,
  parameter int unsigned calib_timeout_cycles_p = 2**24
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      mmcm_locked_i,
  input  logic                      init_calib_complete_i,
  input  logic                      soft_reset_req_i,
  output logic                      host_reset_o,
  output logic                      core_reset_o,
  output logic                      dram_ready_o,
  output logic                      timeout_error_o,
  output logic [state_width_gp-1:0] state_o
);

  if ((sync_stages_p < sync_min_stages_gp) || (host_lead_cycles_p < 1) ||
      (core_hold_cycles_p < 1) || (soft_reset_cycles_p < 1) ||
      (calib_timeout_cycles_p < 1)) begin : g_bad_params
    $fatal(1, "arty_reset_sequencer: illegal parameter value");
  end

  localparam int unsigned max_count_lp =
    max_u(max_u(host_lead_cycles_p, core_hold_cycles_p),
          max_u(soft_reset_cycles_p, calib_timeout_cycles_p));
  localparam int unsigned cnt_width_lp = $clog2(max_count_lp) + 1;

  // Each timed state lasts N cycles: load N-1 on entry, leave when zero.
  localparam logic [cnt_width_lp-1:0] timeout_load_lp = cnt_width_lp'(calib_timeout_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] lead_load_lp    = cnt_width_lp'(host_lead_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] hold_load_lp    = cnt_width_lp'(core_hold_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] soft_load_lp    = cnt_width_lp'(soft_reset_cycles_p - 1);

  logic rst_sync_n;
  logic lock_s;
  logic calib_s;

  arty_rst_state_e state_q, state_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic cnt_zero;

  logic host_reset_d;
  logic core_reset_d;
  logic dram_ready_d;
  logic timeout_error_d;

  // Internal reset: asserts with reset_n_i, releases synchronously.
  arty_sync_bit #(.stages_p(sync_stages_p)) u_rst_sync (
    .clk_i   (clk_i),
    .clr_n_i (reset_n_i),
    .d_i     (1'b1),
    .q_o     (rst_sync_n)
  );

  arty_sync_bit #(.stages_p(sync_stages_p)) u_lock_sync (
    .clk_i   (clk_i),
    .clr_n_i (rst_sync_n),
    .d_i     (mmcm_locked_i),
    .q_o     (lock_s)
  );

  arty_sync_bit #(.stages_p(sync_stages_p)) u_calib_sync (
    .clk_i   (clk_i),
    .clr_n_i (rst_sync_n),
    .d_i     (init_calib_complete_i),
    .q_o     (calib_s)
  );

  assign cnt_zero = (cnt_q == '0);

  // State register.
  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= e_reset;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; lock loss outranks calibration loss and soft requests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_reset: begin
        state_d = e_wait_lock;
      end
      e_wait_lock: begin
        if (lock_s) state_d = e_wait_calib;
      end
      e_wait_calib: begin
        // Calibration arriving on the timeout cycle still counts as success.
        if (!lock_s)       state_d = e_wait_lock;
        else if (calib_s)  state_d = e_host_lead;
        else if (cnt_zero) state_d = e_error;
      end
      e_host_lead: begin
        if (!lock_s)       state_d = e_wait_lock;
        else if (!calib_s) state_d = e_wait_calib;
        else if (cnt_zero) state_d = e_core_hold;
      end
      e_core_hold: begin
        if (!lock_s)       state_d = e_wait_lock;
        else if (!calib_s) state_d = e_wait_calib;
        else if (cnt_zero) state_d = e_run;
      end
      e_run: begin
        if (!lock_s)               state_d = e_wait_lock;
        else if (!calib_s)         state_d = e_wait_calib;
        else if (soft_reset_req_i) state_d = e_soft_rst;
      end
      e_soft_rst: begin
        // Requests arriving here are dropped; the pulse is never stretched.
        if (!lock_s)       state_d = e_wait_lock;
        else if (!calib_s) state_d = e_wait_calib;
        else if (cnt_zero) state_d = e_run;
      end
      e_error: begin
        state_d = e_error;
      end
    endcase
  end

  // Shared down-counter: reloaded on every state change, saturates at zero.
  always_comb begin
    cnt_d = cnt_zero ? '0 : (cnt_q - cnt_width_lp'(1));
    if (state_d != state_q) begin
      case (state_d)
        e_wait_calib: cnt_d = timeout_load_lp;
        e_host_lead:  cnt_d = lead_load_lp;
        e_core_hold:  cnt_d = hold_load_lp;
        e_soft_rst:   cnt_d = soft_load_lp;
        default:      cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Output decode. Resets assert on the same edge as the offending
  // transition but only release one edge after the releasing state is entered.
  // The core-release term also covers the end of a soft pulse so the pulse
  // lasts exactly the SOFT_RST dwell.
  always_comb begin
    host_reset_d    = 1'b1;
    core_reset_d    = 1'b1;
    dram_ready_d    = 1'b0;
    timeout_error_d = timeout_error_o;
    if (host_released(state_q) && host_released(state_d)) begin
      host_reset_d = 1'b0;
    end
    if ((state_d == e_run) && ((state_q == e_run) || (state_q == e_soft_rst))) begin
      core_reset_d = 1'b0;
    end
    dram_ready_d = lock_s & calib_s;
    if (state_d == e_error) begin
      timeout_error_d = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      host_reset_o    <= 1'b1;
      core_reset_o    <= 1'b1;
      dram_ready_o    <= 1'b0;
      timeout_error_o <= 1'b0;
    end else begin
      host_reset_o    <= host_reset_d;
      core_reset_o    <= core_reset_d;
      dram_ready_o    <= dram_ready_d;
      timeout_error_o <= timeout_error_d;
    end
  end

  assign state_o = state_q;

endmodule
